sram_word_ctrl: RTL

SRAM_WORD_CTRL -- requirements
Module: sram_word_ctrl

---
 rtl/sram_ctrl_pkg.sv | 26 ++
 rtl/sram_word_ctrl_phase_counter.sv | 43 ++++
 rtl/sram_word_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg -- shared definitions for the SRAM word controller:
// FSM state encoding, default host base address, SRAM half-word width
// and a small counter-width helper.
package sram_ctrl_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  // Host byte address that maps to SRAM half-word address 0
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // Width of one SRAM data beat
  localparam int SRAM_HW_W = 16;

  // Counter width for a modulus n; never narrower than one bit so a
  // single-beat word still gets a legal (constant zero) counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_word_ctrl_phase_counter.sv
// sram_phase_counter -- beat/phase sequencer for one SRAM word transfer.
// While run is high the phase counter steps 0..PHASES-1 and the beat
// counter advances on every phase wrap; run low parks both at zero so
// each transfer starts at beat 0, phase 0.
module sram_phase_counter
  import sram_ctrl_pkg::*;
#(
  parameter int BEATS   = 2,
  parameter int PHASES  = 2,
  localparam int BEAT_W  = cnt_width(BEATS),
  localparam int PHASE_W = cnt_width(PHASES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [BEAT_W-1:0]  beat,
  output logic [PHASE_W-1:0] phase,
  output logic               last_phase,
  output logic               last_beat
);

  logic [BEAT_W-1:0]  beat_reg;
  logic [PHASE_W-1:0] phase_reg;

  assign beat       = beat_reg;
  assign phase      = phase_reg;
  assign last_phase = (phase_reg == PHASE_W'(PHASES - 1));
  assign last_beat  = (beat_reg == BEAT_W'(BEATS - 1));

  // Step phase every cycle of an active transfer, beat on phase wrap
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      beat_reg  <= '0;
      phase_reg <= '0;
    end else if (last_phase) begin
      phase_reg <= '0;
      beat_reg  <= last_beat ? '0 : beat_reg + BEAT_W'(1);
    end else begin
      phase_reg <= phase_reg + PHASE_W'(1);
    end
  end

endmodule

// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl -- maps DATA_W-bit host reads/writes onto a 16-bit
// asynchronous SRAM as DATA_W/16 beats of WAIT_CYC+1 cycles each, most
// significant half-word first.
// Optional feature: define SRAM_CTRL_BYTE_MASK_EN to add the byte_en
// input and drive UB_N/LB_N from it during writes.
module sram_word_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 18,
  parameter int          WAIT_CYC  = 1,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_enable,
  input  logic                 write_enable,
  input  logic [31:0]          address,
  input  logic [DATA_W-1:0]    write_data,
`ifdef SRAM_CTRL_BYTE_MASK_EN
  input  logic [DATA_W/8-1:0]  byte_en,
`endif
  output logic [DATA_W-1:0]    read_data,
  output logic                 ready,
  inout  wire  [SRAM_HW_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0]    SRAM_ADDR,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_OE_N
);

  localparam int          BEATS       = DATA_W / SRAM_HW_W;
  localparam int          PHASES      = WAIT_CYC + 1;
  localparam int          BEAT_W      = cnt_width(BEATS);
  localparam int          PHASE_W     = cnt_width(PHASES);
  localparam logic [31:0] WORD_BYTES  = 32'(DATA_W / 8);
  // Wide enough for index*BEATS without losing bits below ADDR_W
  localparam int          ADDR_CALC_W = 40;

  ctrl_state_t          state_reg;
  logic [31:0]          address_reg;
  logic [DATA_W-1:0]    write_data_reg;
  logic [DATA_W-1:0]    read_data_reg;

  logic [BEAT_W-1:0]    beat;
  logic [PHASE_W-1:0]   phase;
  logic                 last_phase;
  logic                 last_beat;
  logic                 in_op;
  logic                 op_end;

  logic [31:0]          word_idx;
  logic [SRAM_HW_W-1:0] dq_out;
  logic                 dq_oe;
  logic                 we_n_c;
  logic                 ub_n_c;
  logic                 lb_n_c;

  assign in_op  = (state_reg == READ) || (state_reg == WRITE);
  assign op_end = in_op && last_phase && last_beat;

  sram_phase_counter #(
    .BEATS  (BEATS),
    .PHASES (PHASES)
  ) u_phase_counter (
    .clk        (clk),
    .rst        (rst),
    .run        (in_op),
    .beat       (beat),
    .phase      (phase),
    .last_phase (last_phase),
    .last_beat  (last_beat)
  );

`ifdef SRAM_CTRL_BYTE_MASK_EN
  logic [DATA_W/8-1:0] byte_en_reg;
  logic [BEATS-1:0]    ub_en;
  logic [BEATS-1:0]    lb_en;

  // Per-beat byte lanes: beat gi carries half-word gi counted from the MSB end
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
      assign ub_en[gi] = byte_en_reg[DATA_W/8 - 1 - 2*gi];
      assign lb_en[gi] = byte_en_reg[DATA_W/8 - 2 - 2*gi];
    end
  endgenerate
`endif

  // Main FSM: accept a request in IDLE (read wins), run the beats, one DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      address_reg    <= '0;
      write_data_reg <= '0;
`ifdef SRAM_CTRL_BYTE_MASK_EN
      byte_en_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (read_enable || write_enable) begin
            state_reg      <= read_enable ? READ : WRITE;
            address_reg    <= address;
            write_data_reg <= write_data;
`ifdef SRAM_CTRL_BYTE_MASK_EN
            byte_en_reg    <= byte_en;
`endif
          end
        end
        READ, WRITE: begin
          if (op_end) begin
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Capture the addressed half-word on the last phase of each read beat
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_reg <= '0;
    end else if ((state_reg == READ) && last_phase) begin
      for (int i = 0; i < BEATS; i++) begin
        if (beat == BEAT_W'(i)) begin
          read_data_reg[DATA_W-1-SRAM_HW_W*i -: SRAM_HW_W] <= SRAM_DQ;
        end
      end
    end
  end

  // Select the half-word for the current write beat
  always_comb begin
    dq_out = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (beat == BEAT_W'(i)) begin
        dq_out = write_data_reg[DATA_W-1-SRAM_HW_W*i -: SRAM_HW_W];
      end
    end
  end

  // Strobes: drive DQ for the whole write beat, pulse WE_N after the setup phase
  always_comb begin
    dq_oe  = 1'b0;
    we_n_c = 1'b1;
    ub_n_c = 1'b0;
    lb_n_c = 1'b0;
    if ((state_reg == WRITE) && !rst) begin
      dq_oe = 1'b1;
`ifdef SRAM_CTRL_BYTE_MASK_EN
      ub_n_c = ~ub_en[beat];
      lb_n_c = ~lb_en[beat];
      // A beat with no enabled byte lane skips the write strobe entirely
      we_n_c = (phase == '0) || !(ub_en[beat] || lb_en[beat]);
`else
      we_n_c = (phase == '0);
`endif
    end
  end

  // Word index wraps modulo 2^32 for addresses below BASE_ADDR
  assign word_idx  = (address_reg - BASE_ADDR) / WORD_BYTES;
  assign SRAM_ADDR = in_op ? ADDR_W'(ADDR_CALC_W'(word_idx) * ADDR_CALC_W'(BEATS)
                                     + ADDR_CALC_W'(beat))
                           : '0;

  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
  assign SRAM_WE_N = we_n_c;
  assign SRAM_UB_N = ub_n_c;
  assign SRAM_LB_N = lb_n_c;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign read_data = read_data_reg;

  // Host may proceed in DONE, in an empty IDLE cycle, or while held in reset
  assign ready = rst
              || (state_reg == DONE)
              || ((state_reg == IDLE) && !read_enable && !write_enable);

endmodule
